// File: rtl/uart_pkg.sv
// uart_pkg: register map, STATUS/CTRL bit positions and transmitter state encoding
package uart_pkg;
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_LEVEL = 8;
  localparam int CTRL_IRQ_EN = 0;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
endpackage

// File: rtl/uart_fifo_sync.sv
// uart_fifo_sync: single-clock FIFO; pushes into a full FIFO and pops from an empty one are ignored
module uart_fifo_sync #(
  parameter int Width = 8,
  parameter int Depth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   level_o
);
  localparam int AW = $clog2(Depth);
  localparam int LW = AW + 1;
  logic [Width-1:0] mem [Depth];
  logic [AW-1:0] wptr, rptr;
  logic wr, rd;
  assign wr = push_i & ~full_o;
  assign rd = pop_i & ~empty_o;
  assign full_o = level_o == LW'(Depth);
  assign empty_o = level_o == '0;
  assign data_o = mem[rptr];
  // pointers and occupancy; a simultaneous push and pop leaves the level unchanged
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr <= '0;
      rptr <= '0;
      level_o <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      level_o <= level_o + LW'(wr) - LW'(rd);
    end
  end
  // storage needs no reset: empty_o guards every read
  always_ff @(posedge clk_i) begin
    if (wr) mem[wptr] <= data_i;
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: bus-mapped 8N1 UART transmitter with a TX FIFO and a TX-done interrupt
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int ClockFrequency = 50_000_000,
  parameter int BaudRate       = 115_200,
  parameter int FifoDepth      = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        device_req_i,
  input  logic [31:0] device_addr_i,
  input  logic        device_we_i,
  input  logic [3:0]  device_be_i,
  input  logic [31:0] device_wdata_i,
  output logic        device_rvalid_o,
  output logic [31:0] device_rdata_o,
  output logic        uart_tx_o,
  output logic        uart_irq_o
);
  localparam int ClksPerBit = ClockFrequency / BaudRate;
  localparam int CntW = $clog2(ClksPerBit);
  localparam int LvlW = $clog2(FifoDepth) + 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(ClksPerBit - 1);
  tx_state_e state, state_n;
  logic [CntW-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_n;
  logic [7:0] shreg, shreg_n, fifo_data;
  logic tx_n, pop, full, empty, ovf, irq_en, busy, rd, push, drop, stat_rd, ctrl_wr, last;
  logic [LvlW-1:0] level;
  logic [1:0] sel;
  logic [31:0] status, rd_mux;
  logic unused_bits;
  assign unused_bits = ^{device_addr_i[31:4], device_addr_i[1:0], device_be_i[3:1], device_wdata_i[31:8]};
  assign sel = device_addr_i[3:2];
  assign rd = device_req_i & ~device_we_i;
  assign push = device_req_i & device_we_i & (sel == REG_TXDATA) & device_be_i[0];
  assign ctrl_wr = device_req_i & device_we_i & (sel == REG_CTRL) & device_be_i[0];
  assign drop = push & full;
  assign stat_rd = rd & (sel == REG_STATUS);
  assign busy = state != IDLE;
  assign last = cnt == '0;
  assign rd_mux = sel == REG_STATUS ? status : sel == REG_CTRL ? {31'd0, irq_en} : '0;

  uart_fifo_sync #(.Width(8), .Depth(FifoDepth)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (device_wdata_i[7:0]),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  // STATUS image as seen in the request cycle
  always_comb begin
    status = '0;
    status[ST_FULL] = full;
    status[ST_EMPTY] = empty;
    status[ST_BUSY] = busy;
    status[ST_OVF] = ovf;
    status[ST_LEVEL +: 8] = 8'(level);
  end

  // bus response, CTRL register, sticky overflow and registered interrupt
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      device_rvalid_o <= 1'b0;
      device_rdata_o <= '0;
      irq_en <= 1'b0;
      ovf <= 1'b0;
      uart_irq_o <= 1'b0;
    end else begin
      device_rvalid_o <= device_req_i;
      device_rdata_o <= rd ? rd_mux : '0;
      if (ctrl_wr) irq_en <= device_wdata_i[CTRL_IRQ_EN];
      ovf <= drop | (ovf & ~stat_rd);
      uart_irq_o <= irq_en & empty & ~busy;
    end
  end

  // transmitter registers; reset drops any frame in flight and idles the line
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shreg <= '0;
      uart_tx_o <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_idx <= bit_n;
      shreg <= shreg_n;
      uart_tx_o <= tx_n;
    end
  end

  // framing: each bit lasts ClksPerBit cycles; frames chain back-to-back while bytes remain
  always_comb begin
    state_n = state;
    cnt_n = last ? CntLoad : cnt - 1'b1;
    bit_n = bit_idx;
    shreg_n = shreg;
    tx_n = uart_tx_o;
    pop = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = cnt;
        if (!empty) begin
          pop = 1'b1;
          state_n = START;
          cnt_n = CntLoad;
          shreg_n = fifo_data;
          tx_n = 1'b0;
        end
      end
      START: if (last) begin
        state_n = DATA;
        bit_n = '0;
        tx_n = shreg[0];
      end
      DATA: if (last) begin
        state_n = bit_idx == 3'd7 ? STOP : DATA;
        bit_n = bit_idx + 1'b1;
        shreg_n = shreg >> 1;
        tx_n = bit_idx == 3'd7 ? 1'b1 : shreg[1];
      end
      STOP: if (last) begin
        pop = !empty;
        state_n = empty ? IDLE : START;
        shreg_n = empty ? shreg : fifo_data;
        tx_n = empty;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench with a queue-based reference model of the FIFO and line timing
module tb_uart_tx_fifo;
  localparam int CPB = 10;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * CPB;
  logic clk = 0, rst = 1, req = 0, we = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [3:0] be = 0;
  logic rvalid, tx, irq;
  logic [31:0] rdata;
  int cyc = 0, compared = 0, mismatched = 0;
  logic [7:0] mq[$], exp_tx[$];
  logic [31:0] exp_rd[$];
  int last_pop = -1000;
  bit m_ovf = 0, m_irq_en = 0, m_irq = 0, rv_exp = 0;
  bit in_frame = 0;
  int ph = 0, nframes = 0;
  int starts[$];
  logic [7:0] shb;

  uart_tx_fifo #(.ClockFrequency(50_000_000), .BaudRate(5_000_000), .FifoDepth(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .device_req_i(req), .device_addr_i(addr), .device_we_i(we),
    .device_be_i(be), .device_wdata_i(wdata), .device_rvalid_o(rvalid), .device_rdata_o(rdata),
    .uart_tx_o(tx), .uart_irq_o(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  // reference model: a byte queue plus frame timing, one step per cycle
  always @(negedge clk) begin : model
    logic [31:0] st;
    int pre;
    bit busy_m, drop, nxt_irq;
    chk("irq", {31'd0, irq}, {31'd0, m_irq});
    if (rst) begin
      mq.delete();
      exp_tx.delete();
      m_ovf = 0;
      m_irq_en = 0;
      m_irq = 0;
      last_pop = -1000;
    end else begin
      pre = mq.size();
      busy_m = cyc > last_pop && cyc <= last_pop + FRAME;
      drop = 0;
      st = {16'd0, 8'(pre), 4'd0, m_ovf, busy_m, pre == 0, pre == DEPTH};
      if (req) exp_rd.push_back(we ? 32'd0 : addr[3:2] == 2'd1 ? st : addr[3:2] == 2'd2 ? {31'd0, m_irq_en} : 32'd0);
      nxt_irq = m_irq_en && pre == 0 && !busy_m;
      if (pre > 0 && cyc >= last_pop + FRAME) begin
        exp_tx.push_back(mq.pop_front());
        last_pop = cyc;
      end
      if (req && we && addr[3:2] == 2'd0 && be[0]) begin
        if (pre == DEPTH) begin
          drop = 1;
          m_ovf = 1;
        end else mq.push_back(wdata[7:0]);
      end
      if (req && !we && addr[3:2] == 2'd1 && !drop) m_ovf = 0;
      if (req && we && addr[3:2] == 2'd2 && be[0]) m_irq_en = wdata[0];
      m_irq = nxt_irq;
    end
  end

  // bus monitor: every request gets exactly one response the following cycle
  always @(negedge clk) begin
    chk("rvalid", {31'd0, rvalid}, {31'd0, rv_exp});
    if (rvalid === 1'b1) begin
      if (exp_rd.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL rdata_extra: got response %h, required none (cycle %0d)", rdata, cyc);
      end else chk("rdata", rdata, exp_rd.pop_front());
    end else chk("rdata_idle", rdata, 32'd0);
    rv_exp = req && !rst;
  end

  // serial monitor: decodes 8N1 frames at bit centres and scores them against popped bytes
  always @(negedge clk) begin
    if (in_frame) begin
      ph++;
      if (ph == CPB / 2) chk("start_bit", {31'd0, tx}, 32'd0);
      if (ph >= CPB + CPB / 2 && ph < 9 * CPB && (ph - CPB / 2) % CPB == 0) shb[(ph - CPB - CPB / 2) / CPB] = tx;
      if (ph == 9 * CPB + CPB / 2) chk("stop_bit", {31'd0, tx}, 32'd1);
      if (ph == FRAME - 1) begin
        in_frame = 0;
        nframes++;
        if (exp_tx.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL byte_extra: got frame %h, required none (cycle %0d)", shb, cyc);
        end else chk("byte", {24'd0, shb}, {24'd0, exp_tx.pop_front()});
      end
    end else if (tx === 1'b0) begin
      in_frame = 1;
      ph = 0;
      starts.push_back(cyc);
    end
    if (rst) in_frame = 0;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus(input bit w, input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
    req = 1;
    we = w;
    addr = {28'($urandom), a, 2'($urandom)};
    wdata = d;
    be = b;
    @(posedge clk);
    #1;
    req = 0;
    we = 0;
    be = 0;
  endtask

  task automatic rd_chk(input string n, input logic [1:0] a, input logic [31:0] exp);
    bus(0, a, 32'd0, 4'hF);
    chk({n, "_rvalid"}, {31'd0, rvalid}, 32'd1);
    chk(n, rdata, exp);
  endtask

  initial begin
    logic [7:0] b;
    int nf, n;
    idle(3);
    rst = 0;
    rd_chk("reset_status", 2'd1, 32'h2);
    idle(1);
    chk("rvalid_once", {31'd0, rvalid}, 32'd0);
    chk("reset_tx", {31'd0, tx}, 32'd1);
    b = 8'h55;
    bus(1, 2'd0, 32'h55, 4'h1);
    for (int c = 1; c <= FRAME; c++) begin
      idle(1);
      chk("t55_line", {31'd0, tx}, {31'd0, c <= CPB ? 1'b0 : c <= 9 * CPB ? b[(c - CPB - 1) / CPB] : 1'b1});
    end
    rd_chk("busy_last_stop", 2'd1, 32'h6);
    rd_chk("busy_cleared", 2'd1, 32'h2);
    nf = nframes;
    bus(1, 2'd0, 32'h01, 4'hF);
    bus(1, 2'd0, 32'h02, 4'hF);
    bus(1, 2'd0, 32'h03, 4'hF);
    rd_chk("level_after_pop", 2'd1, 32'h204);
    idle(300);
    n = starts.size();
    chk("three_frames", 32'(nframes - nf), 32'd3);
    chk("gap_1_2", 32'(starts[n-2] - starts[n-3]), 32'(FRAME));
    chk("gap_2_3", 32'(starts[n-1] - starts[n-2]), 32'(FRAME));
    for (int i = 0; i < 18; i++) bus(1, 2'd0, $urandom, 4'hF);
    rd_chk("overflow_status", 2'd1, 32'h100D);
    rd_chk("overflow_cleared", 2'd1, 32'h1005);
    idle(1700);
    chk("drained_17", 32'(nframes - nf), 32'd20);
    bus(1, 2'd0, 32'hAA, 4'hF);
    bus(1, 2'd0, 32'h11, 4'hF);
    bus(1, 2'd0, 32'h22, 4'hF);
    idle(43);
    chk("aa_bit3", {31'd0, tx}, 32'd1);
    rst = 1;
    idle(1);
    rst = 0;
    chk("abort_line", {31'd0, tx}, 32'd1);
    nf = nframes;
    rd_chk("abort_status", 2'd1, 32'h2);
    for (int i = 0; i < 15; i++) begin
      idle(10);
      chk("abort_quiet", {31'd0, tx}, 32'd1);
    end
    chk("abort_no_frame", 32'(nframes), 32'(nf));
    bus(1, 2'd2, 32'h1, 4'h1);
    bus(1, 2'd0, 32'h00, 4'h1);
    for (int c = 1; c <= 150; c++) begin
      idle(1);
      chk("irq_window", {31'd0, irq}, {31'd0, c >= FRAME + 2});
    end
    bus(1, 2'd0, 32'h5A, 4'hF);
    idle(1);
    chk("irq_after_push", {31'd0, irq}, 32'd0);
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: bus(1, 2'd0, $urandom, 4'($urandom_range(0, 15)));
        6: bus(0, 2'd1, $urandom, 4'hF);
        7: bus(1'($urandom), 2'd2, $urandom, 4'($urandom));
        8: bus(1'($urandom), 2'd3, $urandom, 4'($urandom));
        default: bus(0, 2'd0, $urandom, 4'hF);
      endcase
      idle($urandom_range(0, 2));
    end
    idle((DEPTH + 2) * FRAME);
    chk("final_drain", 32'(exp_tx.size() + mq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
